mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported unified instruction/data memory between the CPU fetch stage and the load/store stage, which is the step toward a unified memory from the separate instruction and data memories.
- Both requesters use a req/ack handshake.
- The arbiter sequences each memory access through a fixed-latency protocol and returns read data with a one-cycle ack pulse.
- Data requests have priority, with a starvation guard for fetch.

Parameters:
ADDR_W, 32, byte address width on requester side
DATA_W, 32, data word width (must be 32)
MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata (>=1)
STARVE_LIMIT, 4, max consecutive data grants while a fetch is pending (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held with if_addr until if_ack
if_addr  in  ADDR_W  fetch byte address
if_ack  out  1  one-cycle pulse, fetch complete
if_rdata  out  DATA_W  fetched word, valid when if_ack
d_req  in  1  data request; held with d_we/d_be/d_addr/d_wdata until d_ack
d_we  in  1  1=store, 0=load
d_be  in  4  byte enables for stores
d_addr  in  ADDR_W  data byte address
d_wdata  in  DATA_W  store data
d_ack  out  1  one-cycle pulse, data access complete
d_rdata  out  DATA_W  load word, valid when d_ack (0 for stores)
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_be  out  4  memory byte enables
mem_addr  out  ADDR_W-2  word address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_en
busy  out  1  high in any state except IDLE
owner  out  1  0=fetch, 1=data; owner of the current or last grant

Behaviour:
Reset and clocking:
- Single clock domain.
- reset asynchronously forces state IDLE, starve counter 0, and all outputs 0, including owner, rdata and mem_* registers.

FSM:
- IDLE: if any request is pending, arbitrate, register the winner's fields into the mem_* registers, set owner, go to ISSUE. Otherwise stay.
- ISSUE: one cycle; mem_en=1, mem_we=winner we (fetch: 0), mem_be=d_be for a data store, else 4'hF. Go to WAIT with latency counter = MEM_LATENCY.
- WAIT: mem_en=0. Decrement the counter each cycle. On the cycle the counter equals 1, capture mem_rdata (or 0 for a store) into the owner's rdata register, then go to RESP.
- RESP: pulse the owner's ack for exactly one cycle, then IDLE unconditionally.

Timing and handshake:
- Request seen high at IDLE in cycle 0 gives mem_en in cycle 1 and ack in cycle MEM_LATENCY+2.
- Peak throughput is one access per MEM_LATENCY+3 cycles.
- Requests are sampled only in IDLE. Inputs changing outside IDLE are ignored; requesters must hold fields stable until ack.
- A requester may keep req high after ack; that counts as a new request at the following IDLE.
- if_ack and d_ack are never high simultaneously.
- Non-owner rdata holds its last value.

Arbitration at IDLE:
- Only one request pending: grant it.
- Both pending: grant data unless starve counter == STARVE_LIMIT, in which case grant fetch.
- Starve counter:
  - increments on a data grant while if_req is pending, saturating at STARVE_LIMIT;
  - clears on any fetch grant;
  - clears on a data grant with if_req low.

Addressing:
- mem_addr = addr[ADDR_W-1:2]; addr[1:0] is ignored (no misalignment trap).
- Word addresses wrap naturally.

Reset mid-operation:
- The transaction is dropped and no ack is issued.
- A store already strobed in ISSUE may have completed in memory; that is acceptable.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP};
  - owner_t enum {OWN_IF=0, OWN_D=1};
  - constant BE_ALL=4'hF.
- One sub-module is natural: arb_starve_pick, the combinational grant decision plus the starve counter register.
- The FSM and latency counter stay in the top.

Test Plan:
- Reset then if_req=1, if_addr=0x8, MEM_LATENCY=1, mem word2=0x00100093 -> mem_en in cycle 1 with mem_addr=2, if_ack in cycle 3 with if_rdata=0x00100093, d_ack stays 0.
- d_req store, d_addr=0x4, d_wdata=0xDEADBEEF, d_be=4'hF -> mem_en=mem_we=1 with mem_addr=1 in ISSUE, d_ack at cycle 3, d_rdata=0, subsequent load of 0x4 returns 0xDEADBEEF.
- if_req and d_req both held high continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,IF repeating, acks never overlap.
- MEM_LATENCY=3, load of 0x0 -> ack at cycle 5, rdata equals mem_rdata sampled in cycle 4 only.
- Assert reset in WAIT of a load -> busy, acks and mem_* go 0 immediately; after release with d_req still high, new access completes normally.
- Store with d_be=4'b0011 to 0x0 holding 0xDEADBEEF, wdata 0x0000CAFE -> memory reads back 0xDEADCAFE; addr 0x3 maps to mem_addr=0.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types and constants for the unified memory port arbiter
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/arb_starve_pick.sv
// rtl/arb_starve_pick.sv - data-priority grant decision with a fetch starvation guard
module arb_starve_pick
    import cpu_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   if_req,
    input  logic   d_req,
    input  logic   take,
    output owner_t pick
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_q;
    logic [CW-1:0] starve_d;

    // Fetch wins only when it is alone or has waited out STARVE_LIMIT data grants.
    always_comb begin
        pick = OWN_D;
        if (!d_req) begin
            pick = OWN_IF;
        end else if (if_req && (starve_q == LIMIT)) begin
            pick = OWN_IF;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (take) begin
            if (pick == OWN_IF) begin
                starve_d = '0;
            end else if (if_req) begin
                starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 1'b1;
            end else begin
                starve_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and load/store
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int LW = $clog2(MEM_LATENCY + 1);
    localparam logic [LW-1:0] LAT_INIT = LW'(MEM_LATENCY);
    localparam logic [LW-1:0] LAT_ONE  = LW'(1);

    arb_state_t        state_q,     state_d;
    logic [LW-1:0]     lat_q,       lat_d;
    owner_t            owner_q,     owner_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [3:0]        mem_be_q,    mem_be_d;
    logic [ADDR_W-3:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              if_ack_q,    if_ack_d;
    logic              d_ack_q,     d_ack_d;

    logic   take;
    owner_t pick;

    // Byte lanes within a word are selected by mem_be, so the low address bits carry no meaning here.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

    arb_starve_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .clk   (clk),
        .reset (reset),
        .if_req(if_req),
        .d_req (d_req),
        .take  (take),
        .pick  (pick)
    );

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        owner_d     = owner_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        take        = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    take     = 1'b1;
                    owner_d  = pick;
                    mem_en_d = 1'b1;
                    state_d  = ISSUE;
                    if (pick == OWN_D) begin
                        mem_we_d    = d_we;
                        mem_be_d    = d_we ? d_be : BE_ALL;
                        mem_addr_d  = d_addr[ADDR_W-1:2];
                        mem_wdata_d = d_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_be_d    = BE_ALL;
                        mem_addr_d  = if_addr[ADDR_W-1:2];
                        mem_wdata_d = '0;
                    end
                end
            end
            ISSUE: begin
                lat_d   = LAT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                lat_d = lat_q - 1'b1;
                // Read data lines up with the last wait cycle; the ack is registered into RESP.
                if (lat_q == LAT_ONE) begin
                    state_d = RESP;
                    if (owner_q == OWN_D) begin
                        d_rdata_d = mem_we_q ? '0 : mem_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_ack_d   = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            owner_q     <= OWN_IF;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            owner_q     <= owner_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int LAT   = 1;
    localparam int LIMIT = 4;
    localparam int NV    = 9;
    localparam int NR    = 600;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    logic        if_ack,   d_ack,   mem_en,   mem_we,   busy,   owner;
    logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;

    logic        if_ack_3, d_ack_3, mem_en_3, mem_we_3, busy_3, owner_3;
    logic [31:0] if_rdata_3, d_rdata_3, mem_wdata_3, mem_rdata_3;
    logic [3:0]  mem_be_3;
    logic [29:0] mem_addr_3;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    logic [31:0] mem [0:255];
    logic [31:0] rd_q;
    logic        bd_we;
    logic [7:0]  bd_idx;
    logic [31:0] bd_data;
    logic [31:0] mm [0:255];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(LIMIT)) dut3 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack_3), .if_rdata(if_rdata_3),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack_3), .d_rdata(d_rdata_3),
        .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_be(mem_be_3), .mem_addr(mem_addr_3),
        .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3),
        .busy(busy_3), .owner(owner_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Latency-3 memory stand-in: a different word every cycle, so only one cycle's value is correct.
    assign mem_rdata_3 = {16'hA5A5, cyc[15:0]};

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end else if (mem_en) begin
            rd_q <= mem[mem_addr[7:0]];
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end
    assign mem_rdata = rd_q;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [29:0] exp_maddr;
        logic        exp_mwe;
        logic [3:0]  exp_mbe;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [0:NV-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"},      32'(busy),      32'h0);
        check({tag, "_if_ack"},    32'(if_ack),    32'h0);
        check({tag, "_d_ack"},     32'(d_ack),     32'h0);
        check({tag, "_mem_en"},    32'(mem_en),    32'h0);
        check({tag, "_mem_we"},    32'(mem_we),    32'h0);
        check({tag, "_mem_be"},    32'(mem_be),    32'h0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'h0);
        check({tag, "_mem_wdata"}, mem_wdata,      32'h0);
        check({tag, "_owner"},     32'(owner),     32'h0);
        check({tag, "_if_rdata"},  if_rdata,       32'h0);
        check({tag, "_d_rdata"},   d_rdata,        32'h0);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        @(negedge clk);
        bd_idx  = idx;
        bd_data = data;
        bd_we   = 1'b1;
        mm[idx] = data;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        return $urandom() & 32'hFFFF_FC3F;
    endfunction

    vec_t        v;
    logic        own_ack, oth_ack;
    logic [31:0] prev_oth;
    logic        order [0:9];
    int          ng;
    int          c0;
    logic        if_pend, d_pend, grant_d;
    int          if_at, d_at, busy_until, starve;
    logic [31:0] exp_if, exp_d;
    logic [7:0]  idx;

    initial begin
        reset = 1'b1;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        bd_we = 0; bd_idx = 0; bd_data = 0;
        for (int i = 0; i < 256; i++) mm[i] = 32'h0;

        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0008, 32'h0,         30'h2,         1'b0, 4'hF, 32'h0010_0093};
        vecs[1] = '{1'b1, 1'b1, 4'hF, 32'h0000_0004, 32'hDEAD_BEEF, 30'h1,         1'b1, 4'hF, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 4'h3, 32'h0000_0004, 32'h0,         30'h1,         1'b0, 4'hF, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b1, 4'h3, 32'h0000_0000, 32'h0000_CAFE, 30'h0,         1'b1, 4'h3, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 4'hF, 32'h0000_0003, 32'h0,         30'h0,         1'b0, 4'hF, 32'hDEAD_CAFE};
        vecs[5] = '{1'b0, 1'b0, 4'h0, 32'h0000_0003, 32'h0,         30'h0,         1'b0, 4'hF, 32'hDEAD_CAFE};
        vecs[6] = '{1'b0, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0,         30'h3FFF_FFFF, 1'b0, 4'hF, 32'h1234_5678};
        vecs[7] = '{1'b1, 1'b1, 4'h8, 32'hFFFF_FFFF, 32'hAB00_0000, 30'h3FFF_FFFF, 1'b1, 4'h8, 32'h0};
        vecs[8] = '{1'b1, 1'b0, 4'hF, 32'h0000_03FC, 32'h0,         30'hFF,        1'b0, 4'hF, 32'hAB34_5678};

        repeat (2) @(posedge clk);
        #1 check_zero_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        preload(8'd2, 32'h0010_0093);
        preload(8'd0, 32'hDEAD_BEEF);
        preload(8'd255, 32'h1234_5678);

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            @(negedge clk);
            prev_oth = v.is_d ? if_rdata : d_rdata;
            if (v.is_d) begin
                d_req = 1'b1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
            end else begin
                if_req = 1'b1; if_addr = v.addr;
            end
            for (int k = 1; k <= 4; k++) begin
                @(posedge clk);
                #1;
                own_ack = v.is_d ? d_ack : if_ack;
                oth_ack = v.is_d ? if_ack : d_ack;
                check($sformatf("v%0d_c%0d_own_ack", i, k), 32'(own_ack), 32'(k == 3));
                check($sformatf("v%0d_c%0d_other_ack", i, k), 32'(oth_ack), 32'h0);
                if (k == 1) begin
                    check($sformatf("v%0d_mem_en", i),   32'(mem_en),   32'h1);
                    check($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(v.exp_maddr));
                    check($sformatf("v%0d_mem_we", i),   32'(mem_we),   32'(v.exp_mwe));
                    check($sformatf("v%0d_mem_be", i),   32'(mem_be),   32'(v.exp_mbe));
                    check($sformatf("v%0d_busy", i),     32'(busy),     32'h1);
                    check($sformatf("v%0d_owner", i),    32'(owner),    32'(v.is_d));
                    if (v.exp_mwe) check($sformatf("v%0d_mem_wdata", i), mem_wdata, v.wdata);
                end
                if (k == 2) check($sformatf("v%0d_mem_en_off", i), 32'(mem_en), 32'h0);
                if (k == 3) begin
                    check($sformatf("v%0d_rdata", i), v.is_d ? d_rdata : if_rdata, v.exp_rdata);
                    if_req = 1'b0;
                    d_req  = 1'b0;
                end
            end
            check($sformatf("v%0d_other_rdata_hold", i), v.is_d ? if_rdata : d_rdata, prev_oth);
            check($sformatf("v%0d_idle_busy", i), 32'(busy), 32'h0);
        end

        // Both requesters held high: data wins LIMIT times, then fetch once.
        reset_dut();
        if_req = 1'b1; if_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h4;
        ng = 0;
        for (int c = 0; c < 100 && ng < 10; c++) begin
            @(negedge clk);
            check($sformatf("starve_c%0d_ack_overlap", c), 32'(if_ack & d_ack), 32'h0);
            if (d_ack) begin
                order[ng] = 1'b1; ng++;
            end else if (if_ack) begin
                order[ng] = 1'b0; ng++;
            end
        end
        check("starve_grant_count", 32'(ng), 32'd10);
        for (int i = 0; i < ng; i++) begin
            check($sformatf("starve_grant%0d_is_data", i), 32'(order[i]), 32'((i % 5) != 4));
        end
        if_req = 1'b0; d_req = 1'b0;

        // MEM_LATENCY=3: ack five cycles after the request, data from cycle 4.
        reset_dut();
        c0 = cyc;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("lat3_c%0d_d_ack", k),   32'(d_ack_3),  32'(k == 5));
            check($sformatf("lat3_c%0d_if_ack", k),  32'(if_ack_3), 32'h0);
            check($sformatf("lat3_c%0d_mem_en", k),  32'(mem_en_3), 32'(k == 1));
            if (k == 5) begin
                check("lat3_rdata", d_rdata_3, {16'hA5A5, 16'(c0 + 4)});
                d_req = 1'b0;
            end
        end

        // Reset asserted in WAIT of a load, request left high across it.
        reset_dut();
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h4;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1 check_zero_outputs("midreset");
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("after_reset_c%0d_d_ack", k), 32'(d_ack), 32'(k == 3));
            if (k == 3) begin
                check("after_reset_rdata", d_rdata, 32'hDEAD_BEEF);
                d_req = 1'b0;
            end
        end

        // Random traffic against a transaction-level model of grants, timing and memory.
        reset_dut();
        for (int i = 0; i < 16; i++) preload(8'(i), $urandom());
        if_pend = 0; d_pend = 0; if_at = -1; d_at = -1; busy_until = 0; starve = 0;
        exp_if = 0; exp_d = 0;
        for (int n = 0; n < NR; n++) begin
            @(negedge clk);
            check($sformatf("rnd%0d_if_ack", n), 32'(if_ack), 32'(n == if_at));
            check($sformatf("rnd%0d_d_ack", n),  32'(d_ack),  32'(n == d_at));
            if (n == if_at) check($sformatf("rnd%0d_if_rdata", n), if_rdata, exp_if);
            if (n == d_at)  check($sformatf("rnd%0d_d_rdata", n),  d_rdata,  exp_d);
            if (if_ack) if_pend = 1'b0;
            if (d_ack)  d_pend  = 1'b0;
            if (!if_pend && $urandom_range(0, 2) != 0) begin
                if_pend = 1'b1;
                if_addr = rand_addr();
            end
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_pend  = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_be    = 4'($urandom());
                d_addr  = rand_addr();
                d_wdata = $urandom();
            end
            if_req = if_pend;
            d_req  = d_pend;
            if (n >= busy_until && (if_req || d_req)) begin
                grant_d = d_req && !(if_req && starve == LIMIT);
                if (grant_d && if_req) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
                else starve = 0;
                busy_until = n + LAT + 3;
                if (grant_d) begin
                    d_at = n + LAT + 2;
                    idx  = d_addr[9:2];
                    if (d_we) begin
                        for (int b = 0; b < 4; b++) if (d_be[b]) mm[idx][8*b +: 8] = d_wdata[8*b +: 8];
                        exp_d = 32'h0;
                    end else begin
                        exp_d = mm[idx];
                    end
                end else begin
                    if_at  = n + LAT + 2;
                    idx    = if_addr[9:2];
                    exp_if = mm[idx];
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
